// File: rtl/reg_share_pkg.sv
// Shared types and width helpers for the register-sharing round-robin arbiter.
package reg_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Width of an index into n requesters (owner, rotation pointer).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..hold_max inclusive.
    function automatic int cnt_width(input int hold_max);
        return (hold_max > 0) ? $clog2(hold_max + 1) : 1;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req scanning ptr, ptr+1, ... mod N.
module rr_pick
    import reg_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] winner
);

    int            idx;
    logic [PW-1:0] sel;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        found  = |req;
        winner = '0;
        idx    = 0;
        sel    = '0;
        // Scan from the farthest offset down so the nearest one to ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = PW'(idx);
            if (req[sel]) begin
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Grants one requester at a time ownership of a shared register; the owner
// writes its lane every cycle it keeps req high, up to HOLD_MAX writes per grant.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     wdata,
    output logic [N-1:0]           grant,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);

    localparam int PW = idx_width(N);
    localparam int CW = cnt_width(HOLD_MAX);

    localparam logic [N-1:0]  GRANT_ONE = {{(N - 1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD_MAX - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N - 1);

    state_t                     state;
    logic [PW-1:0]              ptr;
    logic [CW-1:0]              cnt;
    logic                       found;
    logic [PW-1:0]              winner;
    logic                       owner_req;
    logic                       release_now;
    logic [N-1:0][WIDTH-1:0]    lanes;

    assign lanes = wdata;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    // The owner lets go either by dropping req or on its final permitted write.
    assign owner_req   = req[owner];
    assign release_now = (state == OWN) && (!owner_req || (cnt == CNT_LAST));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            busy  <= 1'b0;
            q     <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= GRANT_ONE << winner;
                        owner <= winner;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (owner_req) begin
                        q   <= lanes[owner];
                        cnt <= cnt + 1'b1;
                    end
                    // Owner is kept on release so it remains observable while idle.
                    if (release_now) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
